// File: rtl/montre_de1_cpu_oci_pkg.sv
// Shared parameters, FSM state encoding, trace atom codes and the atom packing helper
// for the Nios II OCI debug-trace frame controller.
package montre_de1_cpu_oci_pkg;

  localparam int ATOM_W  = 2;
  localparam int DEPTH   = 15;
  localparam int CNT_W   = 4;
  localparam int FRAME_W = ATOM_W * DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    DRAIN   = 2'd3
  } dct_state_e;

  localparam logic [ATOM_W-1:0] ATOM_NOP    = 2'b00;
  localparam logic [ATOM_W-1:0] ATOM_SEQ    = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_BRANCH = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_EXCEPT = 2'b11;

  // Write atom a into slot c of buffer b; slot k lives at bits [ATOM_W*k +: ATOM_W].
  function automatic logic [FRAME_W-1:0] pack_atom(input logic [FRAME_W-1:0] b,
                                                   input logic [CNT_W-1:0]   c,
                                                   input logic [ATOM_W-1:0]  a);
    logic [FRAME_W-1:0] r;
    r = b;
    for (int k = 0; k < DEPTH; k++) begin
      if (c == CNT_W'(k)) begin
        r[ATOM_W*k +: ATOM_W] = a;
      end else begin
        r[ATOM_W*k +: ATOM_W] = r[ATOM_W*k +: ATOM_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/montre_de1_cpu_oci_dct_ctrl_if.sv
// Atom input and frame output handshakes of the OCI trace frame controller.
// slave = the controller, master = trace source / trace RAM writer side.
interface montre_de1_cpu_oci_dct_ctrl_if;
  import montre_de1_cpu_oci_pkg::*;

  logic               atom_valid;
  logic [ATOM_W-1:0]  atom_data;
  logic               atom_ready;
  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_data;
  logic [CNT_W-1:0]   frame_count;

  modport master (
    output atom_valid, atom_data, frame_ready,
    input  atom_ready, frame_valid, frame_data, frame_count
  );

  modport slave (
    input  atom_valid, atom_data, frame_ready,
    output atom_ready, frame_valid, frame_data, frame_count
  );
endinterface

// File: rtl/montre_de1_cpu_oci_dct_frame_reg.sv
// Output frame register: captures a transferred frame and holds it stable until the
// sink accepts it; can_load tells the collector when a transfer may happen.
module montre_de1_cpu_oci_dct_frame_reg
  import montre_de1_cpu_oci_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic [CNT_W-1:0]   load_count,
  input  logic               frame_ready,
  output logic               can_load,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  output logic [CNT_W-1:0]   frame_count
);

  logic               valid_q, valid_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;

  assign can_load    = !valid_q || frame_ready;
  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign frame_count = count_q;

  // Load wins over acceptance so back-to-back frames keep valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
    end else if (frame_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Frame state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= {FRAME_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/montre_de1_cpu_oci_dct_ctrl.sv
// Nios II OCI debug-trace collector: packs 2-bit atoms into 15-atom frames and hands them
// to the trace RAM writer. Define OCI_DCT_OVERFLOW_EN to drop atoms instead of stalling.
module montre_de1_cpu_oci_dct_ctrl
  import montre_de1_cpu_oci_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          trace_en,
  input  logic                          flush_req,
  montre_de1_cpu_oci_dct_ctrl_if.slave  bus,
  output logic [FRAME_W-1:0]            dct_buffer,
  output logic [CNT_W-1:0]              dct_count,
  output logic                          test_ending,
  output logic                          overflow
);

  dct_state_e         state_q, state_d;
  logic [FRAME_W-1:0] buf_q, buf_d, base_buf_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d, base_cnt_s;
  logic               test_ending_q, test_ending_d;
  logic               can_load_s, full_s, rdy_s, accept_s, xfer_s;

  assign full_s = (cnt_q == CNT_W'(DEPTH));

`ifdef OCI_DCT_OVERFLOW_EN
  assign rdy_s = trace_en && ((state_q == COLLECT) || (state_q == FULL));
`else
  assign rdy_s = trace_en && (state_q == COLLECT) && (!full_s || can_load_s);
`endif

  // Atoms offered while full with a blocked output are only taken in the drop build.
  assign accept_s = bus.atom_valid && rdy_s && (!full_s || can_load_s);
  assign xfer_s   = can_load_s && (((state_q == COLLECT) && trace_en && full_s) ||
                                   (state_q == FULL) || (state_q == DRAIN));

  // A transfer clears the buffer first, so a same-cycle atom lands in slot 0.
  assign base_buf_s = xfer_s ? {FRAME_W{1'b0}} : buf_q;
  assign base_cnt_s = xfer_s ? {CNT_W{1'b0}} : cnt_q;
  assign buf_d      = accept_s ? pack_atom(base_buf_s, base_cnt_s, bus.atom_data) : base_buf_s;
  assign cnt_d      = accept_s ? (base_cnt_s + CNT_W'(1)) : base_cnt_s;

  assign bus.atom_ready = rdy_s;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = test_ending_q;
  assign test_ending_d  = (state_d == DRAIN);

  // Next-state logic; flushes of an empty buffer and flushes outside COLLECT are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = trace_en ? COLLECT : IDLE;
      COLLECT: begin
        if (!trace_en) begin
          state_d = (cnt_q != {CNT_W{1'b0}}) ? DRAIN : IDLE;
        end else if (full_s && !can_load_s) begin
          state_d = FULL;
        end else if (flush_req && (cnt_d != {CNT_W{1'b0}})) begin
          state_d = DRAIN;
        end else begin
          state_d = COLLECT;
        end
      end
      FULL:    state_d = can_load_s ? COLLECT : FULL;
      DRAIN:   state_d = !can_load_s ? DRAIN : (trace_en ? COLLECT : IDLE);
      default: state_d = IDLE;
    endcase
  end

  // FSM and collect buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      buf_q         <= {FRAME_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      test_ending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      test_ending_q <= test_ending_d;
    end
  end

  montre_de1_cpu_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (xfer_s),
    .load_data   (buf_q),
    .load_count  (cnt_q),
    .frame_ready (bus.frame_ready),
    .can_load    (can_load_s),
    .frame_valid (bus.frame_valid),
    .frame_data  (bus.frame_data),
    .frame_count (bus.frame_count)
  );

`ifdef OCI_DCT_OVERFLOW_EN
  logic       trace_en_q, overflow_q, overflow_d, drop_s;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_s = bus.atom_valid && rdy_s && full_s && !can_load_s;

  // Sticky overflow re-armed on each new trace session; drop count saturates.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (trace_en && !trace_en_q) begin
      overflow_d = 1'b0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? 8'hFF : (drop_cnt_q + 8'd1);
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Overflow tracking registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_en_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      trace_en_q <= trace_en;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
